// File: rtl/cam_scaler_pkg.sv
// Shared types for the camera upscaler.
// Holds the scale modes and the N/D ratio table.
package cam_scaler_pkg;

  typedef enum logic [1:0] {
    SCALE_1X,
    SCALE_2X,
    SCALE_8_3X,
    SCALE_4X
  } scale_mode_t;

  localparam int RW = 4;

  typedef struct packed {
    logic [RW-1:0] n;
    logic [RW-1:0] d;
  } ratio_t;

  function automatic ratio_t ratio_lut(
    input scale_mode_t m
  );
    ratio_t r;
    unique case (m)
      SCALE_1X:   r = '{n: 4'd1, d: 4'd1};
      SCALE_2X:   r = '{n: 4'd2, d: 4'd1};
      SCALE_8_3X: r = '{n: 4'd8, d: 4'd3};
      SCALE_4X:   r = '{n: 4'd4, d: 4'd1};
      default:    r = '{n: 4'd1, d: 4'd1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cam_scaler_delay.sv
// Async-reset shift register used to align
// side-band data with the frame-buffer read latency.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cam_scaler.sv
// Nearest-neighbour upscaler: raster position to
// frame-buffer address via per-axis DDA accumulators.
module cam_scaler
  import cam_scaler_pkg::*;
#(
  parameter int SRC_W    = 240,
  parameter int SRC_H    = 320,
  parameter int H_ACTIVE = 1024,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = 17,
  parameter int BRAM_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        scale_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [PIX_W-1:0]  frame_buff_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [PIX_W-1:0]  cam_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic [1:0]        mode_out
);

  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int SW = 1 + 11 + 10;

  scale_mode_t     mode_q, mode_d;
  ratio_t          rt;
  logic [RW-1:0]   ax_q, ax_d, ax_t;
  logic [RW-1:0]   ay_q, ay_d, ay_t;
  logic [XW-1:0]   sx_q, sx_d;
  logic [YW-1:0]   sy_q, sy_d;
  logic            frame_start;
  logic            line_start;
  logic            x_act;
  logic            in_frame;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0]   s1_q, s1_d, sn;
  logic [PIX_W-1:0] cam_q, cam_d;
  logic [10:0]     hc_q;
  logic [9:0]      vc_q;

  assign line_start  = (hcount_in == 11'd0);
  assign frame_start = line_start && (vcount_in == 10'd0);
  assign x_act       = 32'(hcount_in) < H_ACTIVE;

  // A mode change at frame start already governs pixel (0,0).
  assign mode_d = frame_start ? scale_mode_t'(scale_in) : mode_q;
  assign rt     = ratio_lut(mode_d);

  always_comb begin
    ax_d = ax_q;
    sx_d = sx_q;
    ax_t = ax_q + rt.d;
    if (line_start) begin
      ax_d = '0;
      sx_d = '0;
    end else if (x_act) begin
      if (ax_t >= rt.n) begin
        ax_d = ax_t - rt.n;
        if (sx_q != XW'(SRC_W)) sx_d = sx_q + 1'b1;
      end else begin
        ax_d = ax_t;
      end
    end
  end

  always_comb begin
    ay_d = ay_q;
    sy_d = sy_q;
    ay_t = ay_q + rt.d;
    if (frame_start) begin
      ay_d = '0;
      sy_d = '0;
    end else if (line_start) begin
      if (ay_t >= rt.n) begin
        ay_d = ay_t - rt.n;
        if (sy_q != YW'(SRC_H)) sy_d = sy_q + 1'b1;
      end else begin
        ay_d = ay_t;
      end
    end
  end

  assign in_frame = (sx_d < XW'(SRC_W)) &&
                    (sy_d < YW'(SRC_H));

  always_comb begin
    addr_d = '0;
    if (in_frame) begin
      addr_d = ADDR_W'(sy_d) * ADDR_W'(SRC_W)
             + ADDR_W'(sx_d);
    end
  end

  assign s1_d  = {in_frame, hcount_in, vcount_in};
  assign cam_d = sn[SW-1] ? frame_buff_in : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_q <= SCALE_1X;
      ax_q   <= '0;
      sx_q   <= '0;
      ay_q   <= '0;
      sy_q   <= '0;
      addr_q <= '0;
      s1_q   <= '0;
      cam_q  <= '0;
      hc_q   <= '0;
      vc_q   <= '0;
    end else begin
      mode_q <= mode_d;
      ax_q   <= ax_d;
      sx_q   <= sx_d;
      ay_q   <= ay_d;
      sy_q   <= sy_d;
      addr_q <= addr_d;
      s1_q   <= s1_d;
      cam_q  <= cam_d;
      hc_q   <= sn[19:10];
      vc_q   <= sn[9:0];
    end
  end

  pipe_delay #(
    .WIDTH (SW),
    .DEPTH (BRAM_LAT)
  ) u_align (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (s1_q),
    .q_o   (sn)
  );

  assign addr_out   = addr_q;
  assign cam_out    = cam_q;
  assign hcount_out = hc_q;
  assign vcount_out = vc_q;
  assign mode_out   = mode_q;

endmodule
